mem_port_arbiter: RTL

Sequential arbiter that shares the processor's single-port data/instruction memory between the fetch stage and the execute stage. The execute stage requests are the `mem_read`/`mem_write` strobes produced by the execute-stage control decoder. The block accepts one request at a time, holds the memory address and data stable for the configured access latency, and returns read data with a one-cycle valid pulse. Execute has priority, with a starvation bound that guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_arb_starve_ctr.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_t : FSM states (IDLE, ACC, RESP)
//   owner_t : which stage owns the current access
//   op_t    : read or write
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the execute stage, the shared
// single-port memory and the arbiter.
//   slave  : the arbiter (takes requests and mem_rdata, returns grants,
//            valids, read data and drives the memory address/write side)
//   master : everything around the arbiter (requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    // execute side
    logic              ex_read;
    logic              ex_write;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_gnt;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rdata;

    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ex_read, ex_write, ex_addr, ex_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ex_gnt, ex_valid, ex_rdata,
               mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output if_req, if_addr, ex_read, ex_write, ex_addr, ex_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ex_gnt, ex_valid, ex_rdata,
               mem_addr, mem_wdata, mem_wr
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of execute grants given while fetch was waiting.
//   clock, reset : clock and asynchronous active-low reset
//   if_req       : fetch request level
//   if_gnt       : fetch accept pulse (clears the count)
//   ex_gnt       : execute accept pulse (counts, or clears if fetch idle)
//   at_max       : count has reached STARVE_MAX, fetch must win next
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic ex_gnt,
    output logic at_max
);

    localparam int W = $clog2(STARVE_MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(STARVE_MAX);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (if_gnt) begin
            cnt_q <= '0;
        end else if (ex_gnt) begin
            // Execute overtook a waiting fetch: count it. An uncontested
            // execute grant means fetch is not being starved at all.
            if (!if_req)
                cnt_q <= '0;
            else if (cnt_q != MAX_V)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and execute. One access at
// a time: grant in IDLE, hold address/data in ACC for the access latency,
// one-cycle valid pulse in RESP. Execute has priority unless fetch has
// waited through STARVE_MAX execute grants.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : request/grant/valid for both stages plus memory port
//   busy         : arbiter is not in IDLE
//   err          : sticky, set when ex_read and ex_write are seen together
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    mem_port_arbiter_if.slave bus,
    output logic          busy,
    output logic          err
);

    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ex_rdata_q;
    logic              err_q;

    logic ex_req;
    logic fetch_wins;
    logic if_gnt_c;
    logic ex_gnt_c;
    logic at_max;
    logic last_acc;

    mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clock  (clock),
        .reset  (reset),
        .if_req (bus.if_req),
        .if_gnt (if_gnt_c),
        .ex_gnt (ex_gnt_c),
        .at_max (at_max)
    );

    // Grant selection. The grants are combinational, so they are gated by
    // reset to keep every output at 0 while reset is held.
    always_comb begin
        ex_req     = bus.ex_read | bus.ex_write;
        fetch_wins = bus.if_req & (~ex_req | at_max);
        if_gnt_c   = reset & (state_q == IDLE) & fetch_wins;
        ex_gnt_c   = reset & (state_q == IDLE) & ex_req & ~fetch_wins;
        last_acc   = (state_q == ACC) & (cnt_q == CNT_ONE);
    end

    always_comb begin
        // NOTE: state_d gets its default before the case so every path
        // assigns it and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (if_gnt_c || ex_gnt_c) state_d = ACC;
            ACC:     if (last_acc)             state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the rdata holders are plain registers, not a memory
            // array, so they are reset with everything else and the read
            // data outputs are 0 while in reset.
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop
            // samples pre-edge values and the update order is irrelevant.
            state_q <= state_d;

            if (if_gnt_c) begin
                owner_q <= OWN_IF;
                op_q    <= OP_RD;
                addr_q  <= bus.if_addr;
                cnt_q   <= CNT_W'(LAT);
            end else if (ex_gnt_c) begin
                owner_q <= OWN_EX;
                // read+write together is carried out as a write
                op_q    <= bus.ex_write ? OP_WR : OP_RD;
                addr_q  <= bus.ex_addr;
                wdata_q <= bus.ex_wdata;
                cnt_q   <= bus.ex_write ? CNT_ONE : CNT_W'(LAT);
            end else if (state_q == ACC) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // mem_rdata is valid in the last ACC cycle of a read
            if (last_acc && op_q == OP_RD) begin
                if (owner_q == OWN_IF)
                    if_rdata_q <= bus.mem_rdata;
                else
                    ex_rdata_q <= bus.mem_rdata;
            end

            if (state_q == IDLE && bus.ex_read && bus.ex_write)
                err_q <= 1'b1;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.ex_gnt    = ex_gnt_c;
    assign bus.if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.ex_valid  = (state_q == RESP) && (owner_q == OWN_EX);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ex_rdata  = ex_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    // a write loads cnt = 1, so its single ACC cycle is also its first
    assign bus.mem_wr    = (state_q == ACC) && (op_q == OP_WR) && (cnt_q == CNT_ONE);
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule
